// File: rtl/tlul_mtimer_pkg.sv
// tlul_mtimer_pkg: register offsets, CTRL layout, register decode and byte-mask merge for tlul_mtimer
package tlul_mtimer_pkg;

    localparam logic [4:0] MTIME_LO_OFFSET    = 5'h00;
    localparam logic [4:0] MTIME_HI_OFFSET    = 5'h04;
    localparam logic [4:0] MTIMECMP_LO_OFFSET = 5'h08;
    localparam logic [4:0] MTIMECMP_HI_OFFSET = 5'h0C;
    localparam logic [4:0] CTRL_OFFSET        = 5'h10;
    localparam logic [4:0] PRESCALE_OFFSET    = 5'h14;

    localparam int CTRL_EN_BIT = 0;

    typedef enum logic [2:0] {
        REG_MTIME_LO,
        REG_MTIME_HI,
        REG_MTIMECMP_LO,
        REG_MTIMECMP_HI,
        REG_CTRL,
        REG_PRESCALE,
        REG_NONE
    } mtimer_reg_e;

    function automatic mtimer_reg_e decode_reg(input logic [2:0] word);
        logic [4:0] a;
        a = {word, 2'b00};
        return a == MTIME_LO_OFFSET    ? REG_MTIME_LO    :
               a == MTIME_HI_OFFSET    ? REG_MTIME_HI    :
               a == MTIMECMP_LO_OFFSET ? REG_MTIMECMP_LO :
               a == MTIMECMP_HI_OFFSET ? REG_MTIMECMP_HI :
               a == CTRL_OFFSET        ? REG_CTRL        :
               a == PRESCALE_OFFSET    ? REG_PRESCALE    : REG_NONE;
    endfunction

    function automatic logic [31:0] apply_mask(input logic [31:0] old, input logic [31:0] wdata,
                                               input logic [3:0] mask);
        logic [31:0] bm;
        bm = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
        return (wdata & bm) | (old & ~bm);
    endfunction

endpackage

// File: rtl/tlul_pkg.sv
// tlul_pkg: minimal TL-UL channel types and opcodes shared by the fabric and its devices
//   tl_h2d_t : host-to-device A channel plus d_ready
//   tl_d2h_t : device-to-host D channel plus a_ready
package tlul_pkg;

    localparam logic [2:0] PUT_FULL_DATA    = 3'h0;
    localparam logic [2:0] PUT_PARTIAL_DATA = 3'h1;
    localparam logic [2:0] GET              = 3'h4;
    localparam logic [2:0] ACCESS_ACK       = 3'h0;
    localparam logic [2:0] ACCESS_ACK_DATA  = 3'h1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_mtimer_prescaler.sv
// tlul_mtimer_prescaler: divides the clock by (prescale_i+1) into a one-cycle tick
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   en_i          : counter runs only while high, held at 0 otherwise
//   clr_i         : restart the count (PRESCALE rewritten)
//   prescale_i    : terminal count
//   tick_o        : high in the cycle the count equals prescale_i
module tlul_mtimer_prescaler #(
    parameter int PrescaleWidth = 12
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     en_i,
    input  logic                     clr_i,
    input  logic [PrescaleWidth-1:0] prescale_i,
    output logic                     tick_o
);

    logic [PrescaleWidth-1:0] cnt;

    assign tick_o = en_i && cnt == prescale_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt <= '0;
        else         cnt <= (!en_i || clr_i || tick_o) ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/tlul_mtimer.sv
// tlul_mtimer: TL-UL responder exposing a 64-bit RISC-V mtime/mtimecmp pair with a prescaler
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   tl_i          : A channel request plus d_ready
//   tl_o          : D channel response plus a_ready (one outstanding request, registered response)
//   timer_irq_o   : registered CTRL.EN && mtime >= mtimecmp
//   TLUL_MTIMER_SNAPSHOT_EN : a Get of MTIME_LO latches mtime[63:32], returned by the next MTIME_HI Get
module tlul_mtimer
    import tlul_pkg::*;
    import tlul_mtimer_pkg::*;
#(
    parameter int          PrescaleWidth = 12,
    parameter logic [63:0] ResetMtimecmp = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  tl_h2d_t tl_i,
    output tl_d2h_t tl_o,
    output logic    timer_irq_o
);

    logic [63:0]              mtime, mtime_d, mtimecmp, mtimecmp_d;
    logic                     en, en_d, tick;
    logic [PrescaleWidth-1:0] prescale, prescale_d;
    mtimer_reg_e              sel;
    logic                     a_ready, a_ack, is_get, is_put, a_err, wr, rd;
    logic [31:0]              cur, rdata, wdata, hi_rd;
    logic                     d_valid, d_error;
    logic [2:0]               d_opcode;
    logic [1:0]               d_size;
    logic [7:0]               d_source;
    logic [31:0]              d_data;
    logic                     unused_bits;

    assign unused_bits = ^{tl_i.a_param, tl_i.a_address[31:5]};

    assign sel     = decode_reg(tl_i.a_address[4:2]);
    assign is_get  = tl_i.a_opcode == GET;
    assign is_put  = tl_i.a_opcode == PUT_FULL_DATA || tl_i.a_opcode == PUT_PARTIAL_DATA;
    assign a_err   = sel == REG_NONE || !(is_get || is_put) || tl_i.a_address[1:0] != 2'd0 ||
                     tl_i.a_size != 2'd2;
    assign a_ready = !d_valid || tl_i.d_ready;
    assign a_ack   = tl_i.a_valid && a_ready;
    assign wr      = a_ack && is_put && !a_err;
    assign rd      = a_ack && is_get && !a_err;

    // cur is the live register word; it is also the base a partial write merges into
    always_comb begin
        cur   = sel == REG_MTIME_LO    ? mtime[31:0]                   :
                sel == REG_MTIME_HI    ? mtime[63:32]                  :
                sel == REG_MTIMECMP_LO ? mtimecmp[31:0]                :
                sel == REG_MTIMECMP_HI ? mtimecmp[63:32]               :
                sel == REG_CTRL        ? 32'(en) << CTRL_EN_BIT        :
                sel == REG_PRESCALE    ? 32'(prescale)                 : 32'd0;
        rdata = sel == REG_MTIME_HI ? hi_rd : cur;
        wdata = apply_mask(cur, tl_i.a_data, tl_i.a_mask);
    end

    // a bus write to either mtime half overrides that cycle's tick, without carry into the other half
    always_comb begin
        mtime_d    = wr && sel == REG_MTIME_LO    ? {mtime[63:32], wdata}    :
                     wr && sel == REG_MTIME_HI    ? {wdata, mtime[31:0]}     : mtime + 64'(tick);
        mtimecmp_d = wr && sel == REG_MTIMECMP_LO ? {mtimecmp[63:32], wdata} :
                     wr && sel == REG_MTIMECMP_HI ? {wdata, mtimecmp[31:0]}  : mtimecmp;
        en_d       = wr && sel == REG_CTRL     ? wdata[CTRL_EN_BIT]          : en;
        prescale_d = wr && sel == REG_PRESCALE ? wdata[PrescaleWidth-1:0]    : prescale;
    end

    tlul_mtimer_prescaler #(.PrescaleWidth(PrescaleWidth)) u_prescaler (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .en_i       (en),
        .clr_i      (wr && sel == REG_PRESCALE),
        .prescale_i (prescale),
        .tick_o     (tick)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mtime       <= '0;
            mtimecmp    <= ResetMtimecmp;
            en          <= 1'b0;
            prescale    <= '0;
            timer_irq_o <= 1'b0;
        end else begin
            mtime       <= mtime_d;
            mtimecmp    <= mtimecmp_d;
            en          <= en_d;
            prescale    <= prescale_d;
            timer_irq_o <= en_d && mtime_d >= mtimecmp_d;
        end
    end

`ifdef TLUL_MTIMER_SNAPSHOT_EN
    logic [31:0] shadow;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) shadow <= '0;
        else         shadow <= rd && sel == REG_MTIME_LO ? mtime[63:32] : shadow;
    end
    assign hi_rd = shadow;
`else
    assign hi_rd = mtime[63:32];
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            d_valid  <= 1'b0;
            d_opcode <= '0;
            d_size   <= '0;
            d_source <= '0;
            d_data   <= '0;
            d_error  <= 1'b0;
        end else if (a_ack) begin
            d_valid  <= 1'b1;
            d_opcode <= is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
            d_size   <= tl_i.a_size;
            d_source <= tl_i.a_source;
            d_data   <= rd ? rdata : 32'd0;
            d_error  <= a_err;
        end else if (tl_i.d_ready) begin
            d_valid  <= 1'b0;
        end
    end

    assign tl_o = '{d_valid: d_valid, d_opcode: d_opcode, d_param: 3'd0, d_size: d_size,
                    d_source: d_source, d_sink: 1'b0, d_data: d_data, d_user: 1'b0,
                    d_error: d_error, a_ready: a_ready};

endmodule
